// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DBG   = 2;
  localparam int N_REQ     = 3;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'(REQ_FETCH): return 2'(REQ_DATA);
      2'(REQ_DATA):  return 2'(REQ_DBG);
      default:       return 2'(REQ_FETCH);
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker; the search starts just after
// the previous winner so that no active requester can be starved.
module rr_arbiter3
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic [1:0]       last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = last_grant;
    for (int i = 0; i < N_REQ; i++) begin
      cand = rr_next(cand);
      if (req_valid[cand] && !found) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, load/store and debug onto one memory port and sequences
// every access through ISSUE, a fixed-latency WAIT and a one-cycle RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int LATENCY   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ-1:0][BIT_WIDTH-1:0]  req_addr,
  input  logic [N_REQ-1:0][BIT_WIDTH-1:0]  req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [BIT_WIDTH-1:0]             rsp_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [BIT_WIDTH-1:0]             mem_addr,
  output logic [BIT_WIDTH-1:0]             mem_wdata,
  input  logic [BIT_WIDTH-1:0]             mem_rdata,
  output logic                             busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  arb_state_t           state, state_next;
  logic [1:0]           last_grant, grant_idx;
  logic [N_REQ-1:0]     grant;
  logic                 lat_we;
  logic [BIT_WIDTH-1:0] lat_addr, lat_wdata, rsp_rdata_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 accept;

  rr_arbiter3 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grants are gated by rst so that nothing is accepted while reset is held.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    mem_en     = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (!rst && |req_valid) begin
          req_ready  = grant;
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid[last_grant] = 1'b1;
        state_next            = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // last_grant doubles as the owner of the in-flight access during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 2'(REQ_DBG);
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      wait_cnt    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        lat_we     <= req_we[grant_idx];
        lat_addr   <= req_addr[grant_idx];
        lat_wdata  <= req_wdata[grant_idx];
      end
      if (state == ISSUE) begin
        wait_cnt <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (state == WAIT && wait_cnt == '0) begin
        rsp_rdata_q <= lat_we ? '0 : mem_rdata;
      end
    end
  end

  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign rsp_rdata = rsp_rdata_q;

endmodule
